// File: rtl/mainband_pattern_generator_if.sv
// -----------------------------------------------------------------------------
// mainband_pattern_generator_if
//
// Connects the point-test sequencer to the mainband pattern generator.
//
//   i_mainband_pattern_generator_cw : 2-bit control word
//                                     (00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 NOP)
//   i_val_pattern_en                : 1 = valid-lane pattern, 0 = LFSR data
//   i_burst_count                   : 0 = 1024 UI burst, 1 = 4096 UI burst
//   o_lane_data                     : NUM_LANES words of SER_WIDTH UI, lane n
//                                     at [n*SER_WIDTH +: SER_WIDTH], bit 0 first
//   o_valid_data                    : valid-lane word, bit 0 first
//   o_tx_active                     : a burst word is on the outputs
//   o_pattern_finished              : burst complete, sticky while cw = 10
//
// master : sequencer side (drives the control inputs, observes the outputs)
// slave  : generator side
// -----------------------------------------------------------------------------
interface mainband_pattern_generator_if #(
  parameter int NUM_LANES = 16,
  parameter int SER_WIDTH = 32
);

  logic [1:0]                     i_mainband_pattern_generator_cw;
  logic                           i_val_pattern_en;
  logic                           i_burst_count;
  logic [NUM_LANES*SER_WIDTH-1:0] o_lane_data;
  logic [SER_WIDTH-1:0]           o_valid_data;
  logic                           o_tx_active;
  logic                           o_pattern_finished;

  modport master (
    output i_mainband_pattern_generator_cw,
    output i_val_pattern_en,
    output i_burst_count,
    input  o_lane_data,
    input  o_valid_data,
    input  o_tx_active,
    input  o_pattern_finished
  );

  modport slave (
    input  i_mainband_pattern_generator_cw,
    input  i_val_pattern_en,
    input  i_burst_count,
    output o_lane_data,
    output o_valid_data,
    output o_tx_active,
    output o_pattern_finished
  );

endinterface

// File: rtl/mainband_pattern_generator.sv
// -----------------------------------------------------------------------------
// mainband_pattern_generator
//
// Transmit-side mainband pattern generator for D2C point tests. Executes the
// sequencer's control word and drives either per-lane 23-bit Fibonacci LFSR
// data or the valid-lane 00001111 pattern toward the serializers, then flags
// end-of-burst on o_pattern_finished.
//
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (outputs 0, LFSRs seeded)
//   bus     : mainband_pattern_generator_if.slave (control word, mode
//             selects, lane/valid words, tx_active, pattern_finished)
//
// SER_WIDTH must be a multiple of 8 and divide 1024.
// All outputs are registered: a control word sampled at edge E is reflected
// on the outputs right after E.
// -----------------------------------------------------------------------------
module mainband_pattern_generator #(
  parameter int NUM_LANES = 16,
  parameter int SER_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  mainband_pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CW_IDLE       = 2'b00,
    CW_CLEAR_LFSR = 2'b01,
    CW_LFSR       = 2'b10,
    CW_NOP        = 2'b11
  } cw_e;

  localparam int LW = 23;

  // Last counter value of a burst; the counter runs 0 .. BURST_CYCLES-1.
  localparam logic [11:0] LAST_1K = 12'(1024 / SER_WIDTH - 1);
  localparam logic [11:0] LAST_4K = 12'(4096 / SER_WIDTH - 1);

  // 8'h0F per byte: UI 0..3 high, UI 4..7 low, repeating.
  localparam logic [SER_WIDTH-1:0] VALID_PATTERN = {(SER_WIDTH/8){8'h0F}};

  function automatic logic [LW-1:0] seed_of(input int lane);
    logic [LW-1:0] seed;
    case (lane % 8)
      0:       seed = 23'h1DBFBC;
      1:       seed = 23'h0607BB;
      2:       seed = 23'h1EC760;
      3:       seed = 23'h18C0DB;
      4:       seed = 23'h010F12;
      5:       seed = 23'h19CFC9;
      6:       seed = 23'h0277CE;
      default: seed = 23'h1BB807;
    endcase
    return seed;
  endfunction

  cw_e cw;
  assign cw = cw_e'(bus.i_mainband_pattern_generator_cw);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                         state_q, state_d;
  logic [11:0]                    cnt_q, cnt_d;
  logic                           burst_q, burst_d;   // latched i_burst_count
  logic                           val_q, val_d;       // latched i_val_pattern_en
  logic [LW-1:0]                  lfsr_q [NUM_LANES];
  logic [LW-1:0]                  lfsr_d [NUM_LANES];

  logic [NUM_LANES*SER_WIDTH-1:0] lane_data_q, lane_data_d;
  logic [SER_WIDTH-1:0]           valid_data_q, valid_data_d;
  logic                           tx_active_q, tx_active_d;
  logic                           finished_q, finished_d;

  // ---------------------------------------------------------------------------
  // Per-lane LFSR unrolled SER_WIDTH steps: word bit k is s[22] before step k.
  // ---------------------------------------------------------------------------
  logic [NUM_LANES*SER_WIDTH-1:0] lane_word;
  logic [LW-1:0]                  lfsr_adv [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [SER_WIDTH-1:0] word;
    logic [LW-1:0]        adv;

    // NOTE: blocking assignments here model a chain of combinational steps
    // within one cycle; only clocked state uses non-blocking assignments.
    always_comb begin
      logic [LW-1:0] s;
      s    = lfsr_q[g];
      word = '0;
      for (int k = 0; k < SER_WIDTH; k++) begin
        word[k] = s[22];
        s       = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
      end
      adv = s;
    end

    assign lane_word[g*SER_WIDTH +: SER_WIDTH] = word;
    assign lfsr_adv[g]                         = adv;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic emit;       // a burst word is produced at this edge
  logic eff_val;    // valid-mode select in force for this word
  logic seed_load;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    val_d      = val_q;
    emit       = 1'b0;
    eff_val    = val_q;
    seed_load  = 1'b0;
    finished_d = 1'b0;

    unique case (cw)
      CW_CLEAR_LFSR: begin
        state_d   = ST_SEED;
        cnt_d     = '0;
        seed_load = 1'b1;
      end

      CW_LFSR: begin
        unique case (state_q)
          ST_IDLE, ST_SEED: begin
            // Entry word uses the live mode inputs; they are latched for the
            // remainder of the burst.
            state_d = ST_RUN;
            cnt_d   = '0;
            burst_d = bus.i_burst_count;
            val_d   = bus.i_val_pattern_en;
            eff_val = bus.i_val_pattern_en;
            emit    = 1'b1;
          end
          ST_RUN: begin
            if (cnt_q == (burst_q ? LAST_4K : LAST_1K)) begin
              state_d    = ST_DONE;
              finished_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 12'd1;
              emit  = 1'b1;
            end
          end
          ST_DONE: begin
            finished_d = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      default: begin   // IDLE and NOP
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    for (int l = 0; l < NUM_LANES; l++) begin
      if (seed_load) begin
        lfsr_d[l] = seed_of(l);
      end else if (emit && !eff_val) begin
        lfsr_d[l] = lfsr_adv[l];
      end else begin
        lfsr_d[l] = lfsr_q[l];
      end
    end

    tx_active_d  = emit;
    lane_data_d  = (emit && !eff_val) ? lane_word : '0;
    // Valid lane stays asserted during data training.
    valid_data_d = !emit ? '0 : (eff_val ? VALID_PATTERN : '1);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      burst_q      <= 1'b0;
      val_q        <= 1'b0;
      lane_data_q  <= '0;
      valid_data_q <= '0;
      tx_active_q  <= 1'b0;
      finished_q   <= 1'b0;
      // NOTE: the LFSR array is reset on purpose: it is functional state that
      // must hold the seeds out of reset, not a storage memory.
      for (int l = 0; l < NUM_LANES; l++) begin
        lfsr_q[l] <= seed_of(l);
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_q      <= burst_d;
      val_q        <= val_d;
      lane_data_q  <= lane_data_d;
      valid_data_q <= valid_data_d;
      tx_active_q  <= tx_active_d;
      finished_q   <= finished_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        lfsr_q[l] <= lfsr_d[l];
      end
    end
  end

  assign bus.o_lane_data        = lane_data_q;
  assign bus.o_valid_data       = valid_data_q;
  assign bus.o_tx_active        = tx_active_q;
  assign bus.o_pattern_finished = finished_q;

endmodule

// File: tb/tb_mainband_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_mainband_pattern_generator
//
// Directed bench for mainband_pattern_generator (16 lanes x 32 UI): seeded 1k
// and 4k bursts, valid mode, abort and re-entry, mid-run mode change, and
// asynchronous reset mid-burst. Expected lane words come from an independent
// tap-mask LFSR model kept per seed class (lane mod 8).
// -----------------------------------------------------------------------------
module tb_mainband_pattern_generator;

  localparam int NL = 16;
  localparam int SW = 32;
  localparam logic [SW-1:0] VAL_PAT  = 32'h0F0F0F0F;
  localparam logic [SW-1:0] ALL_ONES = 32'hFFFF_FFFF;
  // Feedback taps 22, 20, 15, 7, 4, 1.
  localparam logic [22:0]   TAPS     = 23'h508092;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mainband_pattern_generator_if #(.NUM_LANES(NL), .SER_WIDTH(SW)) bus ();

  mainband_pattern_generator #(.NUM_LANES(NL), .SER_WIDTH(SW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [22:0] seeds [8] = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                             23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
  logic [22:0] m_state [8];

  task automatic check(input string tag, input logic [NL*SW-1:0] got,
                       input logic [NL*SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reseed();
    for (int i = 0; i < 8; i++) m_state[i] = seeds[i];
  endtask

  task automatic model_next(output logic [NL*SW-1:0] lanes);
    logic [SW-1:0] w [8];
    logic [22:0]   s;
    for (int i = 0; i < 8; i++) begin
      s = m_state[i];
      for (int b = 0; b < SW; b++) begin
        w[i][b] = s[22];
        s       = {s[21:0], ^(s & TAPS)};
      end
      m_state[i] = s;
    end
    for (int l = 0; l < NL; l++) lanes[l*SW +: SW] = w[l % 8];
  endtask

  task automatic seed_cycle();
    bus.i_mainband_pattern_generator_cw = 2'b01;
    tick();
    check("seed.tx_active", bus.o_tx_active, 1'b0);
    model_reseed();
  endtask

  // Drives cw=10 for `words` emitted words, checking each one. With abort set
  // cw drops to 00 after the last word; otherwise the finish sequence is
  // checked. toggle flips i_burst_count after the 5th word.
  task automatic burst(input string tag, input bit bc, input bit ven,
                       input int words, input bit abort, input bit toggle,
                       input bit seeded);
    logic [NL*SW-1:0] exp_lanes;
    logic [22:0]      rev;
    bus.i_mainband_pattern_generator_cw = 2'b10;
    bus.i_burst_count                   = bc;
    bus.i_val_pattern_en                = ven;
    for (int k = 0; k < words; k++) begin
      tick();
      if (ven) exp_lanes = '0;
      else     model_next(exp_lanes);
      check({tag, ".tx_active"},  bus.o_tx_active, 1'b1);
      check({tag, ".lane_data"},  bus.o_lane_data, exp_lanes);
      check({tag, ".valid_data"}, bus.o_valid_data, ven ? VAL_PAT : ALL_ONES);
      check({tag, ".finished"},   bus.o_pattern_finished, 1'b0);
      if (seeded && k == 0) begin
        for (int i = 0; i < 23; i++) rev[i] = seeds[0][22-i];
        check({tag, ".lane0_bitrev"}, bus.o_lane_data[22:0], rev);
        check({tag, ".lane8_bitrev"}, bus.o_lane_data[8*SW +: 23], rev);
      end
      if (toggle && k == 4) bus.i_burst_count = ~bus.i_burst_count;
    end
    if (abort) begin
      bus.i_mainband_pattern_generator_cw = 2'b00;
      tick();
      check({tag, ".abort_tx"},       bus.o_tx_active, 1'b0);
      check({tag, ".abort_lane"},     bus.o_lane_data, '0);
      check({tag, ".abort_valid"},    bus.o_valid_data, '0);
      check({tag, ".abort_finished"}, bus.o_pattern_finished, 1'b0);
      tick();
      check({tag, ".abort_finished2"}, bus.o_pattern_finished, 1'b0);
    end else begin
      tick();
      check({tag, ".end_tx"},       bus.o_tx_active, 1'b0);
      check({tag, ".end_finished"}, bus.o_pattern_finished, 1'b1);
      check({tag, ".end_lane"},     bus.o_lane_data, '0);
      check({tag, ".end_valid"},    bus.o_valid_data, '0);
      tick();
      check({tag, ".hold_finished"}, bus.o_pattern_finished, 1'b1);
      check({tag, ".hold_tx"},       bus.o_tx_active, 1'b0);
      bus.i_mainband_pattern_generator_cw = 2'b00;
      tick();
      check({tag, ".clear_finished"}, bus.o_pattern_finished, 1'b0);
    end
  endtask

  initial begin
    bus.i_mainband_pattern_generator_cw = 2'b00;
    bus.i_val_pattern_en                = 1'b0;
    bus.i_burst_count                   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.lane",     bus.o_lane_data, '0);
    check("reset.valid",    bus.o_valid_data, '0);
    check("reset.tx",       bus.o_tx_active, 1'b0);
    check("reset.finished", bus.o_pattern_finished, 1'b0);
    #3 rst_n = 1'b1;
    tick();

    // Seeded 1k burst: 32 words
    seed_cycle();
    burst("burst1k", 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b1);

    // Seeded 4k burst: 128 words, every lane against the model
    seed_cycle();
    burst("burst4k", 1'b1, 1'b0, 128, 1'b0, 1'b0, 1'b1);

    // Valid mode, then a data burst proves the LFSRs did not move
    burst("valid", 1'b0, 1'b1, 32, 1'b0, 1'b0, 1'b0);
    burst("after_valid", 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b0);

    // Abort after 10 words, re-enter without seeding; burst_count flips mid-run
    seed_cycle();
    burst("abort", 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b1);
    burst("reentry", 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst
    bus.i_mainband_pattern_generator_cw = 2'b10;
    bus.i_burst_count                   = 1'b0;
    bus.i_val_pattern_en                = 1'b0;
    repeat (4) tick();
    check("pre_reset.tx", bus.o_tx_active, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset.lane",     bus.o_lane_data, '0);
    check("async_reset.valid",    bus.o_valid_data, '0);
    check("async_reset.tx",       bus.o_tx_active, 1'b0);
    check("async_reset.finished", bus.o_pattern_finished, 1'b0);
    tick();
    check("in_reset.tx", bus.o_tx_active, 1'b0);
    #3 rst_n = 1'b1;
    model_reseed();
    burst("post_reset", 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
